// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Counter enable generator for the 64-bit timer. Sits between the register
//   block and the counter. It produces a one-cycle count strobe either every
//   clock or every 2^div_val clocks. It also runs the debug-halt handshake,
//   which freezes counting while the CPU holds the timer in debug.
//
// Configuration macro:
//   CNT_CTRL_DBG_HALT_EN - when defined, the HALT state and the
//   halt_req/halt_ack handshake are built. When undefined, halt_req_i and
//   dbg_mode_i are ignored and halt_ack_o is tied low.
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   rst_i        synchronous reset, active-high
//   timer_en_i   timer enable from the control register
//   div_en_i     prescaler enable from the control register
//   div_val_i    divide exponent, period = 2^div_val clocks (clamped to DIV_MAX)
//   halt_req_i   debug halt request
//   dbg_mode_i   CPU debug-mode indication; a halt is honoured only while high
//   cnt_en_o     one-cycle count strobe to the counter
//   halt_ack_o   halt acknowledge, high exactly while halted
//   presc_cnt_o  current prescaler value, for observability
module counter_ctrl #(
  parameter int PRESC_W = 8,
  parameter int DIV_MAX = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               timer_en_i,
  input  logic               div_en_i,
  input  logic [3:0]         div_val_i,
  input  logic               halt_req_i,
  input  logic               dbg_mode_i,
  output logic               cnt_en_o,
  output logic               halt_ack_o,
  output logic [PRESC_W-1:0] presc_cnt_o
);

`ifdef CNT_CTRL_DBG_HALT_EN
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
`else
  typedef enum logic {IDLE, RUN} state_e;
`endif

  localparam logic [3:0] DIV_MAX_L = 4'(DIV_MAX);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] term;
  logic [3:0]         dv, dv_q;
  logic               de_q;
  logic               param_chg;

  // Clamp the exponent, then build the terminal count as a mask of dv ones.
  // This gives (1<<dv)-1 without needing a wider intermediate.
  assign dv        = (div_val_i > DIV_MAX_L) ? DIV_MAX_L : div_val_i;
  assign term      = ~({PRESC_W{1'b1}} << dv);
  assign param_chg = (dv != dv_q) || (div_en_i != de_q);

  // A strobe fires only in RUN. It is suppressed on the cycle the divider
  // settings change, because the prescaler phase restarts on that edge.
  assign cnt_en_o    = (state_q == RUN) && !param_chg &&
                       (!div_en_i || (presc_q == term));
  assign presc_cnt_o = presc_q;

  // Next-state and prescaler logic. Dropping timer_en overrides everything.
  // In HALT the prescaler is untouched, so counting resumes from the frozen phase.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (!timer_en_i) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
        end
        RUN: begin
          if (param_chg || !div_en_i) begin
            presc_d = '0;
          end else if (presc_q == term) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
`ifdef CNT_CTRL_DBG_HALT_EN
          if (halt_req_i && dbg_mode_i) begin
            state_d = HALT;
          end
`endif
        end
`ifdef CNT_CTRL_DBG_HALT_EN
        HALT: begin
          if (!halt_req_i || !dbg_mode_i) begin
            state_d = RUN;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  // State, prescaler and last-seen divider settings.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      presc_q <= '0;
      dv_q    <= '0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dv_q    <= dv;
      de_q    <= div_en_i;
    end
  end

`ifdef CNT_CTRL_DBG_HALT_EN
  logic halt_ack_q;

  // The acknowledge is registered from the next state, so it mirrors
  // state==HALT exactly. A reset clears it on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_ack_q <= 1'b0;
    end else begin
      halt_ack_q <= (state_d == HALT);
    end
  end

  assign halt_ack_o = halt_ack_q;
`else
  logic unused_halt_inputs;
  assign unused_halt_inputs = &{1'b0, halt_req_i, dbg_mode_i};
  assign halt_ack_o         = 1'b0;
`endif

endmodule
